// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-back cache controller:
// controller state encoding and address-width helpers.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      REFILL,
      DONE
   } state_e;

   // CPU/memory address width for the default geometry (20-bit tag, 10-bit index)
   localparam int CACHE_ADDR_W = 30;

   function automatic int cache_addr_w(input int bits_tag, input int bits_direct);
      return bits_tag + bits_direct;
   endfunction

endpackage

// File: rtl/tag_store.sv
// Per-line tag, valid and dirty storage; valid/dirty clear synchronously on gen_reset,
// tags are left untouched since an invalid line never compares as a hit.
module tag_store #(
   parameter int bitsDirect = 10,
   parameter int bitsTag    = 20
) (
   input  logic                  clk,
   input  logic                  gen_reset,
   input  logic [bitsDirect-1:0] idx_i,
   output logic [bitsTag-1:0]    tag_o,
   output logic                  valid_o,
   output logic                  dirty_o,
   input  logic                  set_dirty_i,
   input  logic                  fill_i,
   input  logic [bitsTag-1:0]    fill_tag_i,
   input  logic                  fill_dirty_i
);

   localparam int LINES = 2 ** bitsDirect;

   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;
   logic [bitsTag-1:0] tag_q [LINES];

   always_ff @(posedge clk) begin
      if (gen_reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= fill_dirty_i;
      end else if (set_dirty_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_i) tag_q[idx_i] <= fill_tag_i;
   end

   assign tag_o   = tag_q[idx_i];
   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];

endmodule

// File: rtl/controlador_cache.sv
// Direct-mapped, write-back, write-allocate cache controller (one word per line).
// Define CACHE_STATS_EN to add saturating 32-bit hit_count/miss_count outputs.
module controlador_cache
   import cache_pkg::*;
#(
   parameter int bitsDirect  = 10,
   parameter int sizeBitLine = 64,
   parameter int bitsTag     = 20
) (
`ifdef CACHE_STATS_EN
   output logic [31:0]                   hit_count,
   output logic [31:0]                   miss_count,
`endif
   input  logic                          clk,
   input  logic                          gen_reset,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [bitsTag+bitsDirect-1:0] cpu_addr,
   input  logic [sizeBitLine-1:0]        cpu_wdata,
   output logic [sizeBitLine-1:0]        cpu_rdata,
   output logic                          cpu_ready,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [bitsTag+bitsDirect-1:0] mem_addr,
   output logic [sizeBitLine-1:0]        mem_wdata,
   input  logic [sizeBitLine-1:0]        mem_rdata,
   input  logic                          mem_ack,
   output logic                          write_enable,
   output logic                          read_enable,
   output logic [bitsDirect-1:0]         adress,
   output logic [sizeBitLine-1:0]        data_in,
   input  logic [sizeBitLine-1:0]        data_out
);

   localparam int AW = cache_addr_w(bitsTag, bitsDirect);

   state_e                 state_q, state_d;
   logic                   we_q, we_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [sizeBitLine-1:0] wdata_q, wdata_d;
   logic [sizeBitLine-1:0] rdata_q, rdata_d;
   logic [AW-1:0]          maddr_q, maddr_d;
   logic [sizeBitLine-1:0] mwdata_q, mwdata_d;

   logic [bitsDirect-1:0]  idx;
   logic [bitsTag-1:0]     tag_l;
   logic [bitsTag-1:0]     st_tag;
   logic                   st_valid, st_dirty;
   logic                   hit, set_dirty, fill;

   assign idx   = addr_q[bitsDirect-1:0];
   assign tag_l = addr_q[AW-1:bitsDirect];
   assign hit   = st_valid && (st_tag == tag_l);

   tag_store #(
      .bitsDirect(bitsDirect),
      .bitsTag   (bitsTag)
   ) u_tag_store (
      .clk         (clk),
      .gen_reset   (gen_reset),
      .idx_i       (idx),
      .tag_o       (st_tag),
      .valid_o     (st_valid),
      .dirty_o     (st_dirty),
      .set_dirty_i (set_dirty),
      .fill_i      (fill),
      .fill_tag_i  (tag_l),
      .fill_dirty_i(we_q)
   );

   always_ff @(posedge clk) begin
      if (gen_reset) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (cpu_req) state_d = COMPARE;
         COMPARE: begin
            if (hit)                       state_d = DONE;
            else if (st_valid && st_dirty) state_d = WRITEBACK;
            else                           state_d = REFILL;
         end
         WRITEBACK: if (mem_ack) state_d = REFILL;
         REFILL:    if (mem_ack) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Handshakes and array strobes depend only on state; mem_ack merely qualifies the fill write.
   always_comb begin
      read_enable  = (state_q == COMPARE);
      mem_req      = (state_q == WRITEBACK) || (state_q == REFILL);
      mem_we       = (state_q == WRITEBACK);
      cpu_ready    = (state_q == DONE);
      set_dirty    = (state_q == COMPARE) && hit && we_q;
      fill         = (state_q == REFILL) && mem_ack;
      write_enable = set_dirty || fill;
      data_in      = '0;
      if (set_dirty)  data_in = wdata_q;
      else if (fill)  data_in = we_q ? wdata_q : mem_rdata;
   end

   always_comb begin
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
            end
         end
         COMPARE: begin
            if (hit) begin
               if (!we_q) rdata_d = data_out;
            end else if (st_valid && st_dirty) begin
               maddr_d  = {st_tag, idx};
               mwdata_d = data_out;
            end else begin
               maddr_d  = addr_q;
            end
         end
         WRITEBACK: if (mem_ack) maddr_d = addr_q;
         REFILL:    if (mem_ack && !we_q) rdata_d = mem_rdata;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (gen_reset) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

   assign cpu_rdata = rdata_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;
   assign adress    = idx;

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (gen_reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == COMPARE) begin
         if (hit && (hit_cnt_q != '1))        hit_cnt_q  <= hit_cnt_q + 32'd1;
         else if (!hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_controlador_cache.sv
// Table-driven bench for controlador_cache with a behavioural data array and memory responder.
// Counter checks are included when CACHE_STATS_EN is defined.
module tb_controlador_cache;

   logic        clk = 1'b0;
   logic        gen_reset;
   logic        cpu_req, cpu_we;
   logic [29:0] cpu_addr;
   logic [63:0] cpu_wdata, cpu_rdata;
   logic        cpu_ready;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        write_enable, read_enable;
   logic [9:0]  adress;
   logic [63:0] data_in, data_out;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int total = 0;
   int bad   = 0;

   controlador_cache dut (
`ifdef CACHE_STATS_EN
      .hit_count   (hit_count),
      .miss_count  (miss_count),
`endif
      .clk         (clk),
      .gen_reset   (gen_reset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .write_enable(write_enable),
      .read_enable (read_enable),
      .adress      (adress),
      .data_in     (data_in),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   // Data array: combinational read while read_enable, write on the clock edge.
   logic [63:0] ram [1024];
   initial for (int i = 0; i < 1024; i++) ram[i] = 64'h0;
   always @(posedge clk) if (write_enable) ram[adress] <= data_in;
   assign data_out = read_enable ? ram[adress] : 64'h0;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [63:0] wdata;
      logic [63:0] mrd;
      int          dw;
      int          dr;
      int          exp_wb;
      logic [29:0] wb_addr;
      logic [63:0] wb_data;
      int          exp_rf;
      logic [29:0] rf_addr;
      logic [63:0] exp_rdata;
      int          exp_lat;
      logic        hold;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, input int n);
      int cyc, ph, rdy_n, wb_n, rf_n, lat;
      logic prev_we;
      logic [29:0] wba, rfa;
      logic [63:0] wbd;
      cyc = 0; ph = 0; rdy_n = 0; wb_n = 0; rf_n = 0; lat = 0;
      prev_we = 1'b0; wba = '0; rfa = '0; wbd = '0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; mem_rdata = v.mrd;
      @(posedge clk);
      #1;
      if (v.hold) begin
         cpu_addr = ~v.addr;
         cpu_we   = ~v.we;
      end else begin
         cpu_req = 1'b0;
      end
      while (rdy_n == 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         mem_ack = 1'b0;
         if (cpu_ready) begin
            rdy_n++;
            lat = cyc;
            cpu_req = 1'b0;
         end else if (mem_req) begin
            if (ph == 0 || mem_we != prev_we) begin
               ph = 0;
               if (mem_we) begin wb_n++; wba = mem_addr; wbd = mem_wdata; end
               else begin rf_n++; rfa = mem_addr; end
            end
            prev_we = mem_we;
            ph++;
            if (ph == (mem_we ? v.dw : v.dr) + 1) mem_ack = 1'b1;
         end else begin
            ph = 0;
         end
      end
      chk($sformatf("v%0d ready_seen", n), 64'(rdy_n), 64'd1);
      chk($sformatf("v%0d latency", n), 64'(lat), 64'(v.exp_lat));
      chk($sformatf("v%0d wb_phases", n), 64'(wb_n), 64'(v.exp_wb));
      if (v.exp_wb != 0) begin
         chk($sformatf("v%0d wb_addr", n), 64'(wba), 64'(v.wb_addr));
         chk($sformatf("v%0d wb_data", n), wbd, v.wb_data);
      end
      chk($sformatf("v%0d rf_phases", n), 64'(rf_n), 64'(v.exp_rf));
      if (v.exp_rf != 0) chk($sformatf("v%0d rf_addr", n), 64'(rfa), 64'(v.rf_addr));
      @(negedge clk);
      chk($sformatf("v%0d ready_one_cycle", n), 64'(cpu_ready), 64'd0);
      chk($sformatf("v%0d mem_req_idle", n), 64'(mem_req), 64'd0);
      chk($sformatf("v%0d cpu_rdata", n), cpu_rdata, v.exp_rdata);
   endtask

   initial begin
      vec_t r;
      int rdy;
      vecs[0]  = '{1'b0, 30'h5,        64'h0,    64'hAAAA, 0, 3, 0, 30'h0, 64'h0,    1, 30'h5,        64'hAAAA, 6, 1'b0};
      vecs[1]  = '{1'b0, 30'h5,        64'h0,    64'h0,    0, 0, 0, 30'h0, 64'h0,    0, 30'h0,        64'hAAAA, 2, 1'b0};
      vecs[2]  = '{1'b1, 30'h5,        64'h1234, 64'h0,    0, 0, 0, 30'h0, 64'h0,    0, 30'h0,        64'hAAAA, 2, 1'b0};
      vecs[3]  = '{1'b0, 30'h405,      64'h0,    64'hBBBB, 1, 2, 1, 30'h5, 64'h1234, 1, 30'h405,      64'hBBBB, 7, 1'b0};
      vecs[4]  = '{1'b0, 30'h405,      64'h0,    64'h0,    0, 0, 0, 30'h0, 64'h0,    0, 30'h0,        64'hBBBB, 2, 1'b0};
      vecs[5]  = '{1'b1, 30'h5,        64'h77,   64'hDEAD, 0, 0, 0, 30'h0, 64'h0,    1, 30'h5,        64'hBBBB, 3, 1'b0};
      vecs[6]  = '{1'b0, 30'h5,        64'h0,    64'h0,    0, 0, 0, 30'h0, 64'h0,    0, 30'h0,        64'h77,   2, 1'b0};
      vecs[7]  = '{1'b1, 30'h805,      64'h99,   64'hDEAD, 0, 0, 1, 30'h5, 64'h77,   1, 30'h805,      64'h77,   4, 1'b0};
      vecs[8]  = '{1'b0, 30'h805,      64'h0,    64'h0,    0, 0, 0, 30'h0, 64'h0,    0, 30'h0,        64'h99,   2, 1'b0};
      vecs[9]  = '{1'b0, 30'h3FFFFFFF, 64'h0,    64'hFFFF000011112222, 0, 1, 0, 30'h0, 64'h0, 1, 30'h3FFFFFFF, 64'hFFFF000011112222, 4, 1'b0};
      vecs[10] = '{1'b0, 30'h3FFFFFFF, 64'h0,    64'h0,    0, 0, 0, 30'h0, 64'h0,    0, 30'h0,        64'hFFFF000011112222, 2, 1'b0};
      vecs[11] = '{1'b0, 30'hA,        64'h0,    64'hC0DE, 0, 2, 0, 30'h0, 64'h0,    1, 30'hA,        64'hC0DE, 5, 1'b1};
      vecs[12] = '{1'b0, 30'hA,        64'h0,    64'h0,    0, 0, 0, 30'h0, 64'h0,    0, 30'h0,        64'hC0DE, 2, 1'b0};

      gen_reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst cpu_ready", 64'(cpu_ready), 64'd0);
      chk("rst cpu_rdata", cpu_rdata, 64'd0);
      chk("rst mem_req", 64'(mem_req), 64'd0);
      chk("rst mem_we", 64'(mem_we), 64'd0);
      chk("rst mem_addr", 64'(mem_addr), 64'd0);
      chk("rst mem_wdata", mem_wdata, 64'd0);
      chk("rst write_enable", 64'(write_enable), 64'd0);
      chk("rst read_enable", 64'(read_enable), 64'd0);
      chk("rst data_in", data_in, 64'd0);
`ifdef CACHE_STATS_EN
      chk("rst hit_count", 64'(hit_count), 64'd0);
      chk("rst miss_count", 64'(miss_count), 64'd0);
`endif
      gen_reset = 1'b0;

      // Stray ack while idle must not start anything.
      @(negedge clk); mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      chk("idle ack mem_req", 64'(mem_req), 64'd0);
      chk("idle ack ready", 64'(cpu_ready), 64'd0);
      chk("idle ack read_enable", 64'(read_enable), 64'd0);
      @(negedge clk);
      chk("idle ack mem_req2", 64'(mem_req), 64'd0);

      for (int i = 0; i < 13; i++) begin
         run_txn(vecs[i], i);
`ifdef CACHE_STATS_EN
         if (i == 0) chk("miss_count after first", 64'(miss_count), 64'd1);
         if (i == 1) chk("hit_count after second", 64'(hit_count), 64'd1);
`endif
      end
`ifdef CACHE_STATS_EN
      chk("hit_count total", 64'(hit_count), 64'd7);
      chk("miss_count total", 64'(miss_count), 64'd6);
`endif

      // Reset while refilling: request abandoned, valid bits gone.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h123; mem_rdata = 64'h4444;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("refill reached mem_req", 64'(mem_req), 64'd1);
      chk("refill mem_addr", 64'(mem_addr), 64'h123);
      gen_reset = 1'b1;
      @(negedge clk);
      gen_reset = 1'b0;
      chk("post-reset mem_req", 64'(mem_req), 64'd0);
      chk("post-reset ready", 64'(cpu_ready), 64'd0);
      rdy = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (cpu_ready || mem_req) rdy++;
      end
      chk("abandoned no activity", 64'(rdy), 64'd0);
`ifdef CACHE_STATS_EN
      chk("post-reset hit_count", 64'(hit_count), 64'd0);
      chk("post-reset miss_count", 64'(miss_count), 64'd0);
`endif
      r = '{1'b0, 30'h5, 64'h0, 64'h5555, 0, 0, 0, 30'h0, 64'h0, 1, 30'h5, 64'h5555, 3, 1'b0};
      run_txn(r, 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controlador_cache.md
CONTROLADOR_CACHE -- requirements
Module: controlador_cache

Interface
REQ-001 SHALL have parameter bitsDirect, default 10: index width; the data array holds 2**bitsDirect lines.
REQ-002 SHALL have parameter sizeBitLine, default 64: line and word width; one word per line.
REQ-003 SHALL have parameter bitsTag, default 20: tag width; CPU address width = bitsTag+bitsDirect.
REQ-004 SHALL have ports: clk  in  1  sole clock; gen_reset  in  1  synchronous active-high reset.
REQ-005 SHALL have CPU ports: cpu_req in 1 request; cpu_we in 1 write; cpu_addr in bitsTag+bitsDirect; cpu_wdata in sizeBitLine; cpu_rdata out sizeBitLine; cpu_ready out 1 completion pulse.
REQ-006 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out bitsTag+bitsDirect; mem_wdata out sizeBitLine; mem_rdata in sizeBitLine; mem_ack in 1.
REQ-007 SHALL have data-array ports: write_enable out 1; read_enable out 1; adress out bitsDirect; data_in out sizeBitLine; data_out in sizeBitLine, combinationally valid while read_enable is high.

Function
REQ-008 SHALL be a direct-mapped, write-back, write-allocate controller; index = cpu_addr[bitsDirect-1:0], tag = upper bitsTag bits.
REQ-009 SHALL use states IDLE, COMPARE, WRITEBACK, REFILL, DONE.
REQ-010 IDLE: cpu_req=1 latches cpu_we/cpu_addr/cpu_wdata and moves to COMPARE; cpu_req is ignored in every other state.
REQ-011 COMPARE: read_enable=1, adress=latched index; hit = valid[idx] and stored tag equal to latched tag.
REQ-012 Read hit: cpu_rdata <= data_out; go DONE.
REQ-013 Write hit: write_enable=1 and data_in=latched wdata in the same cycle; dirty[idx] <= 1; go DONE.
REQ-014 Miss with dirty line: register mem_addr={stored tag, idx} and mem_wdata=data_out; go WRITEBACK.
REQ-015 Miss with clean or invalid line: register mem_addr={latched tag, idx}; go REFILL.
REQ-016 WRITEBACK: mem_req=1, mem_we=1 held stable until mem_ack=1; then register mem_addr={latched tag, idx}; go REFILL.
REQ-017 REFILL: mem_req=1, mem_we=0 until mem_ack=1; in the ack cycle write_enable=1, data_in = latched wdata if write else mem_rdata; tag <= latched tag, valid <= 1, dirty <= latched we; read miss sets cpu_rdata <= mem_rdata; go DONE.
REQ-018 DONE: cpu_ready=1 for exactly one cycle; go IDLE; cpu_rdata holds until the next read completes.
REQ-019 Latency: hit = ready 2 cycles after the accepting edge; clean miss = 2 + refill wait + 1; dirty miss adds the writeback wait.
REQ-020 mem_ack outside WRITEBACK/REFILL SHALL be ignored; mem_req, read_enable and write_enable are decoded from state only.

Reset
REQ-021 gen_reset SHALL, on a clk edge, force IDLE and clear all valid and dirty bits; cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, write_enable, read_enable and data_in are 0.
REQ-022 Reset mid-transaction SHALL abandon it with no cpu_ready; mem_req is low in the cycle after reset.
REQ-023 The data array contents are not cleared by this block.

Configuration
REQ-024 With CACHE_STATS_EN defined, the module SHALL add outputs hit_count and miss_count, each 32 bits, saturating, incremented in COMPARE and cleared by reset; without the macro these ports and counters are absent.

Structure
REQ-025 Package cache_pkg SHALL hold the state enum and the address-width localparam.
REQ-026 Tag/valid/dirty storage SHALL be sub-module tag_store with synchronous clear on gen_reset.

Verification
REQ-027 Reset, then read 0x00000005 with memory returning 0xAAAA, ack after 3 cycles -> mem_req read at 0x00000005; cpu_rdata = 0xAAAA; one cpu_ready pulse; miss_count = 1.
REQ-028 Repeat the read of 0x00000005 -> no mem_req; cpu_ready 2 cycles after accept; cpu_rdata = 0xAAAA; hit_count = 1.
REQ-029 Write 0x1234 to 0x00000005, then read 0x00000405 (same index, tag 1) -> writeback at mem_addr 0x00000005 with mem_wdata 0x1234, then refill from 0x00000405.
REQ-030 Assert gen_reset during REFILL -> mem_req low in the next cycle; no cpu_ready; the following read of 0x00000005 misses.
REQ-031 Pulse mem_ack in IDLE and hold cpu_req high during REFILL -> no state change and no second request accepted until DONE.
